// File: rtl/eth_pkg.sv
// eth_pkg -- shared constants and state encoding for the UDP transmit path.
// Rev 1.0
`default_nettype none

package eth_pkg;

  localparam int          UDP_HDR_LEN  = 8;
  localparam logic [15:0] DEFAULT_PORT = 16'd1234;
  localparam logic [7:0]  DEFAULT_TTL  = 8'd64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HDR  = 2'd2,
    ST_SEND = 2'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/udp_tx_buffer_ram.sv
// udp_tx_buffer_ram -- simple dual-port byte RAM, one write port, registered read port.
// Rev 1.0
`default_nettype none

module udp_tx_buffer_ram
  import eth_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  logic [7:0] mem [0:(2**ADDR_WIDTH)-1];

  // No reset on the array or read register so the block maps onto embedded RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/udp_tx_packetizer.sv
// udp_tx_packetizer -- buffers one datagram from a byte stream and emits UDP header + payload.
// Rev 1.0
`default_nettype none

module udp_tx_packetizer
  import eth_pkg::*;
#(
  parameter int          MAX_PAYLOAD    = 1024,
  parameter int          TIMEOUT_CYCLES = 125000,
  parameter logic [15:0] SRC_PORT       = DEFAULT_PORT,
  parameter logic [15:0] DEST_PORT      = DEFAULT_PORT,
  parameter logic [7:0]  IP_TTL         = DEFAULT_TTL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [31:0] local_ip,
  input  logic [31:0] dest_ip,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [5:0]  m_udp_ip_dscp,
  output logic [1:0]  m_udp_ip_ecn,
  output logic [7:0]  m_udp_ip_ttl,
  output logic [31:0] m_udp_ip_source_ip,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,
  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser,
  output logic        busy,
  output logic [15:0] packets_sent
);

  localparam int ADDR_WIDTH = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int CNT_W      = ADDR_WIDTH + 1;
  localparam int TMR_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PAYLOAD);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  tx_state_t        state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [TMR_W-1:0] idle_tmr, idle_tmr_nx;
  logic             close_dgram;

  logic [CNT_W-1:0] rd_ptr;
  logic             rd_en;
  logic [7:0]       ram_data;
  logic             ram_vld, ram_last;
  logic [7:0]       out_data;
  logic             out_vld, out_last;

  logic [31:0]      src_ip_q, dst_ip_q;
  logic [15:0]      len_q;
  logic [15:0]      pkt_cnt;

  logic             in_ready, beat, hdr_fire, out_free, out_fire, ram_adv, send_done;

  assign in_ready  = !rst && ((state == ST_IDLE) || (state == ST_FILL));
  assign beat      = s_axis_tvalid && in_ready;
  assign hdr_fire  = (state == ST_HDR) && m_udp_hdr_ready;
  assign out_free  = !out_vld || m_udp_payload_axis_tready;
  assign out_fire  = out_vld && m_udp_payload_axis_tready;
  assign ram_adv   = ram_vld && out_free;
  assign send_done = out_fire && out_last;

  // A read is issued only when the RAM output stage is empty or draining this cycle,
  // so the read register never overwrites a byte that has not moved forward.
  assign rd_en = (state == ST_SEND) && (rd_ptr != count) && (!ram_vld || out_free);

  udp_tx_buffer_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_buf (
    .clk    (clk),
    .wr_en  (beat),
    .wr_addr(count[ADDR_WIDTH-1:0]),
    .wr_data(s_axis_tdata),
    .rd_en  (rd_en),
    .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data(ram_data)
  );

  always_comb begin
    state_nx    = state;
    count_nx    = count;
    idle_tmr_nx = idle_tmr;
    close_dgram = 1'b0;
    case (state)
      ST_IDLE: begin
        if (beat) begin
          count_nx    = CNT_W'(1);
          idle_tmr_nx = '0;
          if (s_axis_tlast || (MAX_PAYLOAD == 1)) begin
            state_nx    = ST_HDR;
            close_dgram = 1'b1;
          end else begin
            state_nx = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (beat) begin
          count_nx    = count + CNT_W'(1);
          idle_tmr_nx = '0;
        end else begin
          idle_tmr_nx = idle_tmr + TMR_W'(1);
        end
        // A beat landing on the expiry cycle is still written before the close.
        if ((beat && (s_axis_tlast || (count + CNT_W'(1) == MAX_CNT))) ||
            (idle_tmr == TMO_LAST)) begin
          state_nx    = ST_HDR;
          close_dgram = 1'b1;
          idle_tmr_nx = '0;
        end
      end
      ST_HDR: begin
        if (m_udp_hdr_ready) begin
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        if (send_done) begin
          state_nx = ST_IDLE;
          count_nx = '0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        count_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      idle_tmr <= '0;
      rd_ptr   <= '0;
      ram_vld  <= 1'b0;
      ram_last <= 1'b0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      src_ip_q <= '0;
      dst_ip_q <= '0;
      len_q    <= '0;
      pkt_cnt  <= '0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      idle_tmr <= idle_tmr_nx;

      if (close_dgram) begin
        src_ip_q <= local_ip;
        dst_ip_q <= dest_ip;
        len_q    <= 16'(count_nx) + 16'(UDP_HDR_LEN);
      end

      if (hdr_fire) begin
        rd_ptr <= '0;
      end else if (rd_en) begin
        rd_ptr <= rd_ptr + CNT_W'(1);
      end

      if (rd_en) begin
        ram_vld  <= 1'b1;
        ram_last <= (rd_ptr == count - CNT_W'(1));
      end else if (ram_adv) begin
        ram_vld  <= 1'b0;
        ram_last <= 1'b0;
      end

      if (ram_adv) begin
        out_vld  <= 1'b1;
        out_data <= ram_data;
        out_last <= ram_last;
      end else if (out_fire) begin
        out_vld  <= 1'b0;
        out_last <= 1'b0;
      end

      if (send_done) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

  assign s_axis_tready             = in_ready;
  assign m_udp_hdr_valid           = (state == ST_HDR);
  assign m_udp_ip_dscp             = 6'd0;
  assign m_udp_ip_ecn              = 2'd0;
  assign m_udp_ip_ttl              = IP_TTL;
  assign m_udp_ip_source_ip        = src_ip_q;
  assign m_udp_ip_dest_ip          = dst_ip_q;
  assign m_udp_source_port         = SRC_PORT;
  assign m_udp_dest_port           = DEST_PORT;
  assign m_udp_length              = len_q;
  assign m_udp_checksum            = 16'd0;
  assign m_udp_payload_axis_tdata  = out_data;
  assign m_udp_payload_axis_tvalid = out_vld;
  assign m_udp_payload_axis_tlast  = out_last;
  assign m_udp_payload_axis_tuser  = 1'b0;
  assign busy                      = (state != ST_IDLE);
  assign packets_sent              = pkt_cnt;

endmodule

`default_nettype wire

// File: doc/udp_tx_packetizer.md
Name: udp_tx_packetizer

Overview:
Transmit-direction companion to the UDP receive path of the Ethernet subsystem. It accepts an unframed byte stream from the tape datapath and buffers up to one datagram. It then presents a UDP header plus payload on the s_udp_* input of udp_complete, so tape data can be streamed to the host. Datagrams close on input tlast, on reaching MAX_PAYLOAD, or on an input idle timeout.

Parameters:
MAX_PAYLOAD, 1024, maximum payload bytes per datagram (power of two, 8..8192)
ADDR_WIDTH, $clog2(MAX_PAYLOAD), buffer address width (derived, not overridden)
TIMEOUT_CYCLES, 125000, idle cycles in FILL before a partial datagram is flushed (1 ms at 125 MHz)
SRC_PORT, 16'd1234, UDP source port
DEST_PORT, 16'd1234, UDP destination port
IP_TTL, 8'd64, IP TTL field

Ports:
clk  in  1  125 MHz system clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  8  input byte stream
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  end of datagram request
local_ip  in  32  source IP address
dest_ip  in  32  destination IP address
m_udp_hdr_valid  out  1  header valid
m_udp_hdr_ready  in  1  header ready
m_udp_ip_dscp  out  6  constant 0
m_udp_ip_ecn  out  2  constant 0
m_udp_ip_ttl  out  8  IP_TTL
m_udp_ip_source_ip  out  32  latched local_ip
m_udp_ip_dest_ip  out  32  latched dest_ip
m_udp_source_port  out  16  SRC_PORT
m_udp_dest_port  out  16  DEST_PORT
m_udp_length  out  16  payload count + 8
m_udp_checksum  out  16  constant 0 (checksum disabled)
m_udp_payload_axis_tdata  out  8  payload byte
m_udp_payload_axis_tvalid  out  1  payload valid
m_udp_payload_axis_tready  in  1  payload ready
m_udp_payload_axis_tlast  out  1  last payload byte
m_udp_payload_axis_tuser  out  1  constant 0
busy  out  1  high in any state except IDLE
packets_sent  out  16  count of completed datagrams, wraps 0xFFFF->0

Behaviour:
- Reset: state IDLE; s_axis_tready=0 during rst and 1 in the first cycle after reset; hdr_valid, payload tvalid and tlast = 0; count, rd_ptr, idle timer and packets_sent = 0; busy = 0. Reset mid-datagram discards buffered data.
- Single buffer, one byte per cycle. Fill and send never overlap; s_axis_tready = 1 only in IDLE and FILL.
- IDLE: on an accepted beat, write buf[0] and set count=1.
  - If tlast, or if MAX_PAYLOAD==1, go to HDR.
  - Otherwise go to FILL.
- FILL: each accepted beat writes buf[count] and increments count. The idle timer clears on an accepted beat and increments otherwise. The datagram closes into HDR when any of these occurs:
  - an accepted beat carries tlast;
  - count reaches MAX_PAYLOAD after the write;
  - the timer reaches TIMEOUT_CYCLES-1 with no beat.
- If a beat arrives in the same cycle the timeout expires, the beat is accepted and the datagram closes.
- On the transition into HDR, latch local_ip, dest_ip and count. Config changes after that point do not affect the in-flight datagram.
- HDR: hdr_valid=1 and header fields stable; m_udp_length = count+8 (16-bit, max MAX_PAYLOAD+8). On the valid&ready handshake, drop hdr_valid, reset rd_ptr to 0 and go to SEND.
- SEND: buffer read is registered (1-cycle latency), with a prefetch output register; payload tvalid is first asserted 1–2 cycles after the header handshake.
  - Data, tvalid and tlast hold steady while tready is low (AXI-stream rule).
  - tlast=1 exactly on byte index count-1.
  - On the last-byte handshake: tvalid goes to 0, packets_sent increments, and the state returns to IDLE (tready=1 the following cycle).
- A zero-length datagram is impossible, since count >= 1 at close.
- Sustained throughput: one byte per cycle in FILL and in SEND when downstream is ready.

Decomposition:
- Shared package eth_pkg: UDP_HDR_LEN=8, state encoding enum (IDLE, FILL, HDR, SEND), default port/TTL constants.
- One sub-module, udp_tx_buffer_ram: simple dual-port byte RAM, 2**ADDR_WIDTH deep, one write port, registered read port, inferable as Altera M9K/M10K.
- The FSM, counters and output register stay in udp_tx_packetizer.

Test Plan:
- 5 bytes 0x01..0x05 with tlast on byte 5, hdr_ready=1, payload tready=1 -> one header with length=13, checksum=0; payload 01..05 with tlast on 05; packets_sent=1.
- 2500 continuous bytes, no tlast, MAX_PAYLOAD=1024 -> datagrams of 1024, 1024 (length=1032 each), then after TIMEOUT_CYCLES of idle a third of 452 (length=460); s_axis_tready low during each HDR/SEND.
- 3 bytes then input idle; TIMEOUT_CYCLES=100 -> hdr_valid rises exactly 100 cycles after the last accepted beat, length=11.
- hdr_ready held low 50 cycles, then payload tready toggled 1/0 -> header fields stable while stalled; no payload beat lost or duplicated; tdata held during every stall.
- dest_ip changed during HDR -> header keeps the latched value; the next datagram uses the new value.
- rst asserted mid-SEND after 10 of 40 bytes -> next cycle all valids are 0 and packets_sent=0; a new 4-byte frame then sends correctly with length=12.
